machine_timer: RTL and testbench
================================

Name: machine_timer

Overview:
- Upstream real-time source for the machine counter block.
- Holds the 64-bit mtime counter, advanced by a programmable prescaler tick, and the 64-bit mtimecmp compare register.
- Drives real_time_out, which feeds the counter's real_time_in, and raises the machine timer interrupt (mtip) to the interrupt/trap logic.
- Software reaches both registers through a simple 32-bit memory-mapped request/acknowledge port.

Parameters:
- TICK_DIV, 100: clk_in cycles per mtime increment; legal range 1..65535; 1 = increment every cycle.
- MTIME_RESET, 64'h0: reset value of mtime.
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp; no interrupt out of reset.

Ports:
- clk_in  input  1  single clock, rising edge
- rst_in  input  1  reset, asynchronous, active-low
- timer_en_in  input  1  1 = prescaler and mtime advance; 0 = both hold
- bus_req_in  input  1  access request, sampled every rising edge
- bus_we_in  input  1  1 = write, 0 = read; qualified by bus_req_in
- bus_addr_in  input  4  byte offset: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32]
- bus_wdata_in  input  32  write data
- bus_rdata_out  output  32  read data, valid while bus_ack_out=1
- bus_ack_out  output  1  access completion pulse
- real_time_out  output  64  current mtime value (register output)
- mtip_out  output  1  machine timer interrupt pending, level

Behaviour:
- Reset (rst_in=0, async assert, sync release):
  - mtime=MTIME_RESET, mtimecmp=MTIMECMP_RESET, prescaler count=0.
  - bus_ack_out=0, bus_rdata_out=0, mtip_out=0.
  - Reset asserted mid-access aborts the access; no ack is issued afterwards.
- Prescaler:
  - Counts 0..TICK_DIV-1 while timer_en_in=1 and wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - TICK_DIV=1: tick is constant 1 while enabled.
  - timer_en_in=0: count freezes, tick=0.
- mtime:
  - On tick, mtime <= mtime+1, modulo 2^64.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes:
  - Take effect at the edge where bus_req_in=1 and bus_we_in=1.
  - Only the addressed 32-bit half is replaced; the other half holds.
  - Write to either mtime half in a tick cycle: the write wins and there is no increment that cycle. The prescaler is not reset by the write.
  - Writes to mtimecmp do not affect mtime or the prescaler.
- Reads:
  - Sample the register value before any same-edge update.
  - Returned on bus_rdata_out in the following cycle.
- Handshake:
  - bus_ack_out=1 exactly one cycle after each sampled request.
  - Back-to-back requests get back-to-back acks; throughput is 1 per cycle, with no stall.
  - bus_rdata_out=0 during write acks and when bus_ack_out=0.
- Address handling:
  - bus_addr_in[1:0] is ignored.
  - Only offsets 0x0, 0x4, 0x8 and 0xC exist. Any other value of bus_addr_in[3:2] is impossible, because 4 bits cover exactly these four words.
- real_time_out equals the mtime register, with zero added latency.
- mtip_out:
  - Registered (mtime >= mtimecmp), unsigned 64-bit, computed from current register values.
  - Reflects any mtime or mtimecmp change one cycle after the register updates.
  - Level output; it clears only by raising mtimecmp, or by mtime wrapping below mtimecmp.
- Hi/lo tearing:
  - Software must read hi, lo, hi and retry on a mismatch.
  - Hardware provides no atomic 64-bit snapshot.

Decomposition:
- Shared package machine_timer_pkg holds:
  - Offset constants MTIME_LO_OFF=4'h0, MTIME_HI_OFF=4'h4, MTIMECMP_LO_OFF=4'h8, MTIMECMP_HI_OFF=4'hC.
  - Default reset constants for mtime and mtimecmp.
- Sub-module timer_prescaler:
  - Ports: clk_in, rst_in, en_in; output tick_out; parameter TICK_DIV.
  - 16-bit counter.
- Top level holds the registers, bus decode, ack/rdata pipeline stage and compare flop.

Test Plan:
- Reset, TICK_DIV=4, timer_en_in=1 -> real_time_out increments every 4 cycles (0,0,0,1,...); mtip_out=0; bus_ack_out=0.
- Write 32'h0000_0010 to 0x8, then 32'h0 to 0xC -> mtip_out rises exactly 1 cycle after real_time_out reaches 64'h10.
- Write 32'hFFFF_FFFF to 0x0 and 0x4 -> after the next tick real_time_out=0; with mtimecmp=64'h10, mtip_out drops 1 cycle later.
- Write 32'h0000_1234 to 0x0 in the same cycle as a tick -> mtime[31:0]=32'h1234, not 32'h1235; the next increment follows TICK_DIV cycles after the previous tick.
- Back-to-back reads of 0x8, 0xC, 0x0 on consecutive cycles -> three consecutive acks carrying mtimecmp lo, mtimecmp hi, mtime lo; rdata=0 on a write ack.
- timer_en_in=0 for 10 cycles -> real_time_out and prescaler frozen; assert rst_in=0 mid-read -> bus_ack_out=0 immediately, all registers at reset values.

Source files
------------

// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register offsets, reset defaults
// and the decode from a bus byte offset to a register half.
package machine_timer_pkg;

    localparam logic [3:0] MTIME_LO_OFF    = 4'h0;
    localparam logic [3:0] MTIME_HI_OFF    = 4'h4;
    localparam logic [3:0] MTIMECMP_LO_OFF = 4'h8;
    localparam logic [3:0] MTIMECMP_HI_OFF = 4'hC;

    localparam logic [63:0] MTIME_RESET_DEFAULT    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SEL_MTIME_LO    = 2'd0,
        SEL_MTIME_HI    = 2'd1,
        SEL_MTIMECMP_LO = 2'd2,
        SEL_MTIMECMP_HI = 2'd3
    } reg_sel_e;

    // Byte-lane bits are ignored; the four word offsets cover every address.
    function automatic reg_sel_e decode_addr(input logic [3:0] addr);
        reg_sel_e sel;
        case ({addr[3:2], 2'b00})
            MTIME_LO_OFF:    sel = SEL_MTIME_LO;
            MTIME_HI_OFF:    sel = SEL_MTIME_HI;
            MTIMECMP_LO_OFF: sel = SEL_MTIMECMP_LO;
            MTIMECMP_HI_OFF: sel = SEL_MTIMECMP_HI;
            default:         sel = SEL_MTIMECMP_HI;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Programmable prescaler: emits one tick every TICK_DIV enabled cycles,
// and holds its phase while disabled.
module timer_prescaler #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    output logic tick_out
);

    localparam logic [15:0] LAST_COUNT = 16'(TICK_DIV - 32'd1);

    logic [15:0] count_r;

    // Phase counter 0..TICK_DIV-1; with TICK_DIV=1 it stays at 0 and ticks every cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_r <= 16'd0;
        end else if (en_in) begin
            if (count_r == LAST_COUNT) begin
                count_r <= 16'd0;
            end else begin
                count_r <= count_r + 16'd1;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick_out = en_in && (count_r == LAST_COUNT);

endmodule

// File: rtl/machine_timer.sv
// 64-bit mtime/mtimecmp machine timer with a 32-bit request/acknowledge port
// and a registered level interrupt.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 100,
    parameter logic [63:0] MTIME_RESET    = MTIME_RESET_DEFAULT,
    parameter logic [63:0] MTIMECMP_RESET = MTIMECMP_RESET_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        timer_en_in,
    input  logic        bus_req_in,
    input  logic        bus_we_in,
    input  logic [3:0]  bus_addr_in,
    input  logic [31:0] bus_wdata_in,
    output logic [31:0] bus_rdata_out,
    output logic        bus_ack_out,
    output logic [63:0] real_time_out,
    output logic        mtip_out
);

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtime_nxt_s;
    logic [63:0] mtimecmp_nxt_s;
    logic [31:0] rdata_r;
    logic [31:0] rdata_nxt_s;
    logic        ack_r;
    logic        mtip_r;
    logic        tick_s;
    logic        wr_s;
    logic        rd_s;
    reg_sel_e    sel_s;

    timer_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_in    (timer_en_in),
        .tick_out (tick_s)
    );

    assign wr_s  = bus_req_in && bus_we_in;
    assign rd_s  = bus_req_in && !bus_we_in;
    assign sel_s = decode_addr(bus_addr_in);

    // Next-state for the registers and read data; a write to mtime overrides a same-cycle tick.
    always_comb begin
        mtime_nxt_s    = mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        rdata_nxt_s    = 32'h0000_0000;
        if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
        if (wr_s) begin
            case (sel_s)
                SEL_MTIME_LO:    mtime_nxt_s    = {mtime_r[63:32], bus_wdata_in};
                SEL_MTIME_HI:    mtime_nxt_s    = {bus_wdata_in, mtime_r[31:0]};
                SEL_MTIMECMP_LO: mtimecmp_nxt_s = {mtimecmp_r[63:32], bus_wdata_in};
                SEL_MTIMECMP_HI: mtimecmp_nxt_s = {bus_wdata_in, mtimecmp_r[31:0]};
                default:         mtimecmp_nxt_s = mtimecmp_r;
            endcase
        end else if (rd_s) begin
            case (sel_s)
                SEL_MTIME_LO:    rdata_nxt_s = mtime_r[31:0];
                SEL_MTIME_HI:    rdata_nxt_s = mtime_r[63:32];
                SEL_MTIMECMP_LO: rdata_nxt_s = mtimecmp_r[31:0];
                SEL_MTIMECMP_HI: rdata_nxt_s = mtimecmp_r[63:32];
                default:         rdata_nxt_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_nxt_s = 32'h0000_0000;
        end
    end

    // Register state, response stage and interrupt compare.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mtime_r    <= MTIME_RESET;
            mtimecmp_r <= MTIMECMP_RESET;
            rdata_r    <= 32'h0000_0000;
            ack_r      <= 1'b0;
            mtip_r     <= 1'b0;
        end else begin
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            rdata_r    <= rdata_nxt_s;
            ack_r      <= bus_req_in;
            mtip_r     <= (mtime_r >= mtimecmp_r);
        end
    end

    assign bus_rdata_out = rdata_r;
    assign bus_ack_out   = ack_r;
    assign real_time_out = mtime_r;
    assign mtip_out      = mtip_r;

endmodule

// File: tb/tb_machine_timer.sv
// Randomised scoreboard bench for machine_timer against a behavioural model
// driven by enabled-cycle arithmetic.
module tb_machine_timer;

    localparam int unsigned TD = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        timer_en_in;
    logic        bus_req_in;
    logic        bus_we_in;
    logic [3:0]  bus_addr_in;
    logic [31:0] bus_wdata_in;
    logic [31:0] bus_rdata_out;
    logic        bus_ack_out;
    logic [63:0] real_time_out;
    logic        mtip_out;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [63:0]  m_mtime = 64'h0;
    logic [63:0]  m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic         m_mtip  = 1'b0;
    int unsigned  m_en_cycles = 0;
    logic [31:0]  sb_q[$];
    logic [63:0]  old_t;
    logic [63:0]  old_c;
    logic         m_tick;

    always #5 clk_in = ~clk_in;

    machine_timer #(
        .TICK_DIV       (TD),
        .MTIME_RESET    (64'h0),
        .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .timer_en_in   (timer_en_in),
        .bus_req_in    (bus_req_in),
        .bus_we_in     (bus_we_in),
        .bus_addr_in   (bus_addr_in),
        .bus_wdata_in  (bus_wdata_in),
        .bus_rdata_out (bus_rdata_out),
        .bus_ack_out   (bus_ack_out),
        .real_time_out (real_time_out),
        .mtip_out      (mtip_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mtime advances on every TD-th enabled cycle; reads see pre-edge values.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_mtime     = 64'h0;
            m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;
            m_mtip      = 1'b0;
            m_en_cycles = 0;
            sb_q.delete();
        end else begin
            old_t  = m_mtime;
            old_c  = m_cmp;
            m_tick = timer_en_in && ((m_en_cycles % TD) == TD - 1);
            if (timer_en_in) m_en_cycles++;
            if (m_tick) m_mtime = old_t + 64'd1;
            if (bus_req_in) begin
                if (bus_we_in) begin
                    sb_q.push_back(32'h0);
                    case (bus_addr_in[3:2])
                        2'd0:    m_mtime = {old_t[63:32], bus_wdata_in};
                        2'd1:    m_mtime = {bus_wdata_in, old_t[31:0]};
                        2'd2:    m_cmp   = {old_c[63:32], bus_wdata_in};
                        default: m_cmp   = {bus_wdata_in, old_c[31:0]};
                    endcase
                end else begin
                    case (bus_addr_in[3:2])
                        2'd0:    sb_q.push_back(old_t[31:0]);
                        2'd1:    sb_q.push_back(old_t[63:32]);
                        2'd2:    sb_q.push_back(old_c[31:0]);
                        default: sb_q.push_back(old_c[63:32]);
                    endcase
                end
            end
            m_mtip = (old_t >= old_c);
        end
    end

    // Monitor: every issued request must be acknowledged on the next cycle with its data.
    always @(negedge clk_in) begin
        if (sb_q.size() > 0) begin
            check("ack", {63'h0, bus_ack_out}, 64'd1);
            check("rdata", {32'h0, bus_rdata_out}, {32'h0, sb_q.pop_front()});
        end else begin
            check("ack_idle", {63'h0, bus_ack_out}, 64'd0);
            check("rdata_idle", {32'h0, bus_rdata_out}, 64'd0);
        end
        check("real_time", real_time_out, m_mtime);
        check("mtip", {63'h0, mtip_out}, {63'h0, m_mtip});
    end

    task automatic drive(input logic req, input logic we, input logic [3:0] addr,
                         input logic [31:0] wd, input logic en);
        @(negedge clk_in);
        #1;
        bus_req_in   = req;
        bus_we_in    = we;
        bus_addr_in  = addr;
        bus_wdata_in = wd;
        timer_en_in  = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    endtask

    logic [63:0] snap;
    logic        found;

    initial begin
        rst_in       = 1'b0;
        timer_en_in  = 1'b1;
        bus_req_in   = 1'b0;
        bus_we_in    = 1'b0;
        bus_addr_in  = 4'h0;
        bus_wdata_in = 32'h0;
        repeat (3) @(negedge clk_in);
        #1;
        check("reset_rt", real_time_out, 64'h0);
        check("reset_ack", {63'h0, bus_ack_out}, 64'd0);
        check("reset_mtip", {63'h0, mtip_out}, 64'd0);
        rst_in = 1'b1;
        idle(12);

        // Compare at 0x10, then wait past the crossing
        drive(1'b1, 1'b1, 4'h8, 32'h0000_0010, 1'b1);
        drive(1'b1, 1'b1, 4'hC, 32'h0000_0000, 1'b1);
        idle(60);
        check("mtip_set", {63'h0, mtip_out}, 64'd1);

        // Wrap through all-ones
        drive(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1);
        drive(1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF, 1'b1);
        idle(3 * TD);

        // Write lower half in a tick cycle
        found = 1'b0;
        for (int i = 0; i < 2 * TD && !found; i++) begin
            @(negedge clk_in);
            #1;
            if ((m_en_cycles % TD) == TD - 1) begin
                found = 1'b1;
                bus_req_in = 1'b1; bus_we_in = 1'b1; bus_addr_in = 4'h0;
                bus_wdata_in = 32'h0000_1234; timer_en_in = 1'b1;
            end else begin
                bus_req_in = 1'b0; bus_we_in = 1'b0; bus_addr_in = 4'h0;
                bus_wdata_in = 32'h0; timer_en_in = 1'b1;
            end
        end
        check("tick_align_found", {63'h0, found}, 64'd1);
        idle(1);
        check("tick_write", {32'h0, real_time_out[31:0]}, 64'h1234);
        idle(TD - 1);
        check("tick_write_hold", {32'h0, real_time_out[31:0]}, 64'h1234);
        idle(1);
        check("tick_after", {32'h0, real_time_out[31:0]}, 64'h1235);

        // Back-to-back reads then a write ack
        drive(1'b1, 1'b0, 4'h8, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 4'hC, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 4'h1, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 4'hB, 32'h0000_2000, 1'b1);
        idle(2);

        // Disabled timer holds
        snap = m_mtime;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        idle(1);
        check("frozen", real_time_out, snap);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 2), 1'($urandom % 2), 4'($urandom),
                  ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 48),
                  1'(($urandom % 8) != 0));
        end
        idle(2);

        // Reset in the middle of a read
        drive(1'b1, 1'b0, 4'h8, 32'h0, 1'b1);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("rst_ack", {63'h0, bus_ack_out}, 64'd0);
        check("rst_rdata", {32'h0, bus_rdata_out}, 64'd0);
        check("rst_rt", real_time_out, 64'h0);
        check("rst_mtip", {63'h0, mtip_out}, 64'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        rst_in = 1'b1;
        drive(1'b1, 1'b0, 4'h8, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 4'hC, 32'h0, 1'b1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
